// File: rtl/mem_wb_stage_pkg.sv
// ============================================================================
//  Module      : mem_wb_stage_pkg
//  Description : Shared constants and state encoding for the memory/writeback stage.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package mem_wb_stage_pkg;

    localparam int MW_ADDR_SIZE = 8;

    typedef enum logic [1:0] {
        MW_IDLE      = 2'd0,
        MW_REQ       = 2'd1,
        MW_WAIT_DATA = 2'd2,
        MW_WB        = 2'd3
    } mw_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_mem_port_ctrl.sv
// ============================================================================
//  Module      : mem_port_ctrl
//  Description : Data-memory ready/valid handshake FSM and request registers.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_port_ctrl
    import mem_wb_stage_pkg::*;
#(
    parameter int REG_SIZE  = 16,
    parameter int ADDR_SIZE = MW_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 start_is_load,
    input  logic [ADDR_SIZE-1:0] start_addr,
    input  logic [REG_SIZE-1:0]  start_wdata,
    input  logic                 mem_ready,
    input  logic                 mem_rdata_valid,
    output logic [1:0]           state,
    output logic                 capture,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [REG_SIZE-1:0]  mem_wdata
);

    mw_state_t state_q;
    mw_state_t state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are only loaded on acceptance, so they stay stable for the whole REQ phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            mem_we    <= ~start_is_load;
            mem_addr  <= start_addr;
            mem_wdata <= start_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            MW_IDLE: begin
                if (start) begin
                    state_d = MW_REQ;
                end
            end
            MW_REQ: begin
                if (mem_ready) begin
                    if (mem_we) begin
                        state_d = MW_IDLE;
                    end else if (mem_rdata_valid) begin
                        capture = 1'b1;
                        state_d = MW_WB;
                    end else begin
                        state_d = MW_WAIT_DATA;
                    end
                end
            end
            MW_WAIT_DATA: begin
                if (mem_rdata_valid) begin
                    capture = 1'b1;
                    state_d = MW_WB;
                end
            end
            MW_WB: begin
                state_d = MW_IDLE;
            end
            default: begin
                state_d = MW_IDLE;
            end
        endcase
    end

    assign mem_req = (state_q == MW_REQ);
    assign state   = state_q;

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Memory/writeback stage feeding the register-file writeback bus.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int REG_SIZE     = 16,
    parameter int REG_PTR_SIZE = 3,
    parameter int ADDR_SIZE    = MW_ADDR_SIZE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    X_valid,
    input  logic [REG_PTR_SIZE-1:0] X_insn_dst,
    input  logic [REG_PTR_SIZE-1:0] X_insn_src_0,
    input  logic                    X_insn_is_F1,
    input  logic                    X_insn_is_F2,
    input  logic                    X_is_load,
    input  logic                    X_is_store,
    input  logic [REG_SIZE-1:0]     X_alu_result,
    input  logic [REG_SIZE-1:0]     X_store_data,
    output logic                    M_stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_SIZE-1:0]    mem_addr,
    output logic [REG_SIZE-1:0]     mem_wdata,
    input  logic                    mem_ready,
    input  logic                    mem_rdata_valid,
    input  logic [REG_SIZE-1:0]     mem_rdata,
    output logic [REG_SIZE-1:0]     W_result,
    output logic [REG_PTR_SIZE-1:0] MW_insn_dst,
    output logic [REG_PTR_SIZE-1:0] MW_insn_src_0,
    output logic                    MW_insn_is_F1,
    output logic                    MW_insn_is_F2
);

    logic [1:0]              state;
    logic                    capture;
    logic                    accept;
    logic                    is_mem;
    logic [REG_PTR_SIZE-1:0] pend_dst;
    logic [REG_PTR_SIZE-1:0] pend_src_0;
    logic                    pend_f1;
    logic                    pend_f2;

    assign M_stall = (state != MW_IDLE);
    assign accept  = X_valid & ~M_stall;
    assign is_mem  = X_is_load | X_is_store;

    mem_port_ctrl #(
        .REG_SIZE  (REG_SIZE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem_port_ctrl (
        .clk             (clk),
        .reset           (reset),
        .start           (accept & is_mem),
        .start_is_load   (X_is_load),
        .start_addr      (X_alu_result[ADDR_SIZE-1:0]),
        .start_wdata     (X_store_data),
        .mem_ready       (mem_ready),
        .mem_rdata_valid (mem_rdata_valid),
        .state           (state),
        .capture         (capture),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata)
    );

    // Write flags of a memory op are parked here; a store parks zeros so it never strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_dst   <= '0;
            pend_src_0 <= '0;
            pend_f1    <= 1'b0;
            pend_f2    <= 1'b0;
        end else if (accept && is_mem) begin
            pend_dst   <= X_insn_dst;
            pend_src_0 <= X_insn_src_0;
            pend_f1    <= X_insn_is_F1 & X_is_load;
            pend_f2    <= X_insn_is_F2 & X_is_load;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            W_result      <= '0;
            MW_insn_dst   <= '0;
            MW_insn_src_0 <= '0;
            MW_insn_is_F1 <= 1'b0;
            MW_insn_is_F2 <= 1'b0;
        end else begin
            MW_insn_is_F1 <= 1'b0;
            MW_insn_is_F2 <= 1'b0;
            if (accept && !is_mem) begin
                W_result      <= X_alu_result;
                MW_insn_dst   <= X_insn_dst;
                MW_insn_src_0 <= X_insn_src_0;
                MW_insn_is_F1 <= X_insn_is_F1;
                MW_insn_is_F2 <= X_insn_is_F2;
            end else if (capture) begin
                W_result      <= mem_rdata;
                MW_insn_dst   <= pend_dst;
                MW_insn_src_0 <= pend_src_0;
                MW_insn_is_F1 <= pend_f1;
                MW_insn_is_F2 <= pend_f2;
            end
        end
    end

endmodule

`default_nettype wire
